// File: rtl/sum_checker.sv
// sum_checker: monitors an ALU result against a+b, counting cycles and mismatches.
// Define SUM_CHECKER_LOG_EN to capture cycle/operands of the first failure.
module sum_checker #(
   parameter int WIDTH      = 4,
   parameter int CNT_W      = 8,
   parameter int ARM_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] ans,
   input  logic             chk_en,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_fail_cycle
);
   typedef enum logic [1:0] {ARM = 2'b00, CHECK = 2'b01, FAIL = 2'b10} state_e;
   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
   state_e state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, err_q, err_d;
   logic seen_q, seen_d;
   logic [WIDTH-1:0] sum;
   logic qual, mism, armed_next;
   assign sum = a + b;
   assign qual = chk_en && (cyc_q >= CNT_W'(ARM_CYCLES));
   assign mism = qual && (ans != sum);
   // one bit wider so k+1 cannot wrap when the counter saturates
   assign armed_next = ({1'b0, cyc_q} + (CNT_W+1)'(1)) >= (CNT_W+1)'(ARM_CYCLES);
   always_ff @(posedge clk) begin
      if (rst) state_q <= ARM;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == FAIL || mism) ? FAIL :
                (state_q == ARM && !armed_next) ? ARM : CHECK;
   end
   always_comb begin
      pass  = (state_q == CHECK) && seen_q;
      fail  = (state_q == FAIL);
      state = state_q;
   end
   always_comb begin
      cyc_d  = (cyc_q == CMAX) ? cyc_q : cyc_q + CNT_W'(1);
      err_d  = (mism && err_q != CMAX) ? err_q + CNT_W'(1) : err_q;
      seen_d = seen_q | (qual && !mism);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         err_q  <= '0;
         seen_q <= 1'b0;
      end else begin
         cyc_q  <= cyc_d;
         err_q  <= err_d;
         seen_q <= seen_d;
      end
   end
   assign cycle_count = cyc_q;
   assign err_count   = err_q;
`ifdef SUM_CHECKER_LOG_EN
   logic [CNT_W-1:0] ffc_q;
   logic [WIDTH-1:0] cap_a_q, cap_b_q, cap_ans_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         ffc_q     <= '0;
         cap_a_q   <= '0;
         cap_b_q   <= '0;
         cap_ans_q <= '0;
      end else if (state_q != FAIL && state_d == FAIL) begin
         ffc_q     <= cyc_q;
         cap_a_q   <= a;
         cap_b_q   <= b;
         cap_ans_q <= ans;
`ifndef SYNTHESIS
         $display("sum_checker: first mismatch k=%0d a=%0d b=%0d ans=%0d", cyc_q, a, b, ans);
`endif
      end
   end
   assign first_fail_cycle = ffc_q;
`else
   assign first_fail_cycle = '0;
`endif
endmodule

// File: tb/tb_sum_checker.sv
// tb_sum_checker: three checker instances (default, ARM_CYCLES=10, CNT_W=4) fed by an
// add-then-subtract ALU model, compared every cycle against a behavioural model.
module tb_sum_checker;
   logic clk = 1'b0, rst = 1'b1, chk_en = 1'b0;
   logic [3:0] a = '0, b = '0, ans = '0;
   wire [2:0] p, f;
   wire [2:0][1:0] st;
   wire [2:0][7:0] cc, ec, ff;
   wire [3:0] cc2, ec2, ff2;
   int total = 0, bad = 0;
   int mk[3], merr[3], mffc[3];
   bit mfail[3], mmatch[3], mrun[3];
   int arm[3] = '{0, 10, 0};
   int mx[3]  = '{255, 255, 15};
   int alu_cnt = 0;
   bit on = 0;

   always #5 clk = ~clk;

   sum_checker #(.WIDTH(4), .CNT_W(8), .ARM_CYCLES(0)) d0 (
      .clk(clk), .rst(rst), .a(a), .b(b), .ans(ans), .chk_en(chk_en),
      .pass(p[0]), .fail(f[0]), .state(st[0]), .cycle_count(cc[0]),
      .err_count(ec[0]), .first_fail_cycle(ff[0]));
   sum_checker #(.WIDTH(4), .CNT_W(8), .ARM_CYCLES(10)) d1 (
      .clk(clk), .rst(rst), .a(a), .b(b), .ans(ans), .chk_en(chk_en),
      .pass(p[1]), .fail(f[1]), .state(st[1]), .cycle_count(cc[1]),
      .err_count(ec[1]), .first_fail_cycle(ff[1]));
   sum_checker #(.WIDTH(4), .CNT_W(4), .ARM_CYCLES(0)) d2 (
      .clk(clk), .rst(rst), .a(a), .b(b), .ans(ans), .chk_en(chk_en),
      .pass(p[2]), .fail(f[2]), .state(st[2]), .cycle_count(cc2),
      .err_count(ec2), .first_fail_cycle(ff2));
   assign cc[2] = {4'b0, cc2};
   assign ec[2] = {4'b0, ec2};
   assign ff[2] = {4'b0, ff2};

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] alu(input logic [3:0] x, input logic [3:0] y);
      return (alu_cnt >= 8) ? x - y : x + y;
   endfunction

   // model update from the values sampled at this edge
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            mk[i] = 0; merr[i] = 0; mffc[i] = 0;
            mfail[i] = 0; mmatch[i] = 0; mrun[i] = 0;
         end else begin
            bit q, mm;
            q  = chk_en && (mk[i] >= arm[i]);
            mm = q && (int'(ans) != ((int'(a) + int'(b)) % 16));
            if (mm) begin
               if (merr[i] < mx[i]) merr[i]++;
               if (!mfail[i]) begin mfail[i] = 1; mffc[i] = mk[i]; end
            end else if (q) mmatch[i] = 1;
            if (mk[i] < mx[i]) mk[i]++;
            mrun[i] = 1;
         end
      end
      alu_cnt = rst ? 0 : (alu_cnt + 1) % 16;
      on = 1;
      #1;
   endtask

   task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic en, input logic r);
      a = av; b = bv; chk_en = en; rst = r;
      ans = alu(av, bv);
      tick();
   endtask

   always @(negedge clk) begin
      if (on) begin
         for (int i = 0; i < 3; i++) begin
            int es;
            es = mfail[i] ? 2 : ((mrun[i] && mk[i] >= arm[i]) ? 1 : 0);
            chk($sformatf("state%0d", i), 32'(st[i]), es);
            chk($sformatf("fail%0d", i), 32'(f[i]), 32'(mfail[i]));
            chk($sformatf("pass%0d", i), 32'(p[i]), 32'((es == 1) && mmatch[i]));
            chk($sformatf("cycle%0d", i), 32'(cc[i]), mk[i]);
            chk($sformatf("err%0d", i), 32'(ec[i]), merr[i]);
`ifdef SUM_CHECKER_LOG_EN
            chk($sformatf("ffc%0d", i), 32'(ff[i]), mffc[i]);
`else
            chk($sformatf("ffc%0d", i), 32'(ff[i]), 0);
`endif
         end
      end
   end

   initial begin
      drive(0, 0, 0, 1);
      chk("rst_state", 32'(st[0]), 0);
      chk("rst_cycle", 32'(cc[0]), 0);
      for (int k = 0; k < 24; k++) begin
         drive(3, 2, 1, 0);
         if (k == 7) begin
            chk("s1_pass7", 32'(p[0]), 1);
            chk("s1_nofail7", 32'(f[0]), 0);
         end
         if (k == 8) begin
            chk("s1_fail8", 32'(f[0]), 1);
            chk("s1_err8", 32'(ec[0]), 1);
            chk("s1_state8", 32'(st[0]), 2);
            chk("s1_pass8", 32'(p[0]), 0);
`ifdef SUM_CHECKER_LOG_EN
            chk("s1_ffc8", 32'(ff[0]), 8);
`endif
         end
      end
      chk("s3_err", 32'(ec[0]), 8);
      chk("s3_state", 32'(st[0]), 2);
      chk("s4_err", 32'(ec[1]), 6);
`ifdef SUM_CHECKER_LOG_EN
      chk("s3_ffc", 32'(ff[0]), 8);
      chk("s4_ffc", 32'(ff[1]), 10);
`endif
      drive(0, 0, 0, 1);
      for (int k = 0; k < 40; k++) begin
         drive(3, 0, 1, 0);
         if (k == 19) chk("sat_cycle", 32'(cc[2]), 15);
      end
      chk("s2_cycle", 32'(cc[0]), 40);
      chk("s2_pass", 32'(p[0]), 1);
      chk("s2_err", 32'(ec[0]), 0);
      drive(0, 0, 0, 1);
      for (int k = 0; k < 25; k++) begin
         drive(3, 2, !(k >= 8 && k <= 15), 0);
         if (k == 23) chk("s5_nofail23", 32'(f[0]), 0);
         if (k == 24) begin
            chk("s5_fail24", 32'(f[0]), 1);
            chk("s5_err24", 32'(ec[0]), 1);
         end
      end
      drive(0, 0, 0, 1);
      for (int k = 0; k < 8; k++) drive(3, 2, 1, 0);
      a = 3; b = 2; chk_en = 1; rst = 1; ans = 4'd9;
      tick();
      chk("rstmm_fail", 32'(f[0]), 0);
      chk("rstmm_err", 32'(ec[0]), 0);
      chk("rstmm_state", 32'(st[0]), 0);
      chk("rstmm_pass", 32'(p[0]), 0);
      for (int n = 0; n < 3000; n++) begin
         a = 4'($urandom); b = 4'($urandom);
         chk_en = ($urandom % 4) != 0;
         rst = ($urandom % 300) == 0;
         ans = (($urandom % 50) == 0) ? 4'($urandom) : alu(a, b);
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
